// File: rtl/key_note_encoder.sv
// rtl/key_note_encoder.sv - debounced 13-key scanner to note code with sustain tail
// Lowest pressed key wins; the note is held RELEASE_CYCLES after the last release.
module key_note_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_CYCLES  = 8
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [12:0] iKeys,
  output logic [7:0]  oNote,
  output logic        oNoteValid,
  output logic [12:0] oKeysStable
);

  localparam logic [7:0]  DebLast = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] RelLast = 16'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;

  logic [12:0] sync1_q, sync2_q;
  logic [12:0] stable_q, stable_d;
  logic [7:0]  cnt_q [13];
  logic [7:0]  cnt_d [13];
  logic [7:0]  win;
  state_t      state_q, state_d;
  logic [7:0]  note_q, note_d;
  logic        valid_q, valid_d;
  logic [15:0] sus_q, sus_d;

  // A key flips only after its mismatch has persisted DEBOUNCE_CYCLES edges.
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 13; k++) begin
      cnt_d[k] = 8'd0;
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == DebLast) begin
          stable_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    win = 8'd0;
    for (int i = 12; i >= 0; i--) begin
      if (stable_q[i]) begin
        win = 8'(i + 1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int k = 0; k < 13; k++) begin
        cnt_q[k] <= '0;
      end
      state_q  <= IDLE;
      note_q   <= '0;
      valid_q  <= 1'b0;
      sus_q    <= '0;
    end else begin
      sync1_q  <= iKeys;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int k = 0; k < 13; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      state_q  <= state_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      sus_q    <= sus_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win != 8'd0) state_d = PLAY;
      PLAY:    if (win == 8'd0) state_d = SUSTAIN;
      SUSTAIN: begin
        if (win != 8'd0) begin
          state_d = PLAY;
        end else if (sus_q == 16'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new key during SUSTAIN wins over expiry on the same edge.
  always_comb begin
    note_d = note_q;
    sus_d  = sus_q;
    case (state_q)
      IDLE: note_d = win;
      PLAY: begin
        if (win != 8'd0) begin
          note_d = win;
        end else begin
          sus_d = RelLast;
        end
      end
      SUSTAIN: begin
        if (win != 8'd0) begin
          note_d = win;
        end else if (sus_q == 16'd0) begin
          note_d = 8'd0;
        end else begin
          sus_d = sus_q - 16'd1;
        end
      end
      default: note_d = 8'd0;
    endcase
    valid_d = (note_d != 8'd0) && (note_d != note_q);
  end

  assign oNote       = note_q;
  assign oNoteValid  = valid_q;
  assign oKeysStable = stable_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// tb/tb_key_note_encoder.sv - directed table plus hand sequences for key_note_encoder
module tb_key_note_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] keys;
  logic [7:0]  note;
  logic        nvalid;
  logic [12:0] kstable;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  typedef struct {
    logic [12:0] keys;
    int          hold;
    logic [7:0]  note;
    logic [12:0] stable;
    int          strobes;
  } vec_t;

  vec_t vecs [4];

  key_note_encoder #(.DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(8)) dut (
    .iClk        (clk),
    .iReset      (rst),
    .iKeys       (keys),
    .oNote       (note),
    .oNoteValid  (nvalid),
    .oKeysStable (kstable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (nvalid) strobes++;
    check("note_legal", 32'((note <= 8'd13) && !(nvalid && note == 8'd0)), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vecs[0] = '{keys: 13'h0005, hold: 12, note: 8'd1,  stable: 13'h0005, strobes: 1};
    vecs[1] = '{keys: 13'h0004, hold: 12, note: 8'd3,  stable: 13'h0004, strobes: 1};
    vecs[2] = '{keys: 13'h1004, hold: 12, note: 8'd3,  stable: 13'h1004, strobes: 0};
    vecs[3] = '{keys: 13'h1000, hold: 12, note: 8'd13, stable: 13'h1000, strobes: 1};

    rst  = 1'b1;
    keys = 13'h0;
    ticks(2);
    check("reset_note", 32'(note), 32'd0);
    check("reset_valid", 32'(nvalid), 32'd0);
    check("reset_stable", 32'(kstable), 32'd0);
    rst = 1'b0;
    ticks(3);

    // First-press latency: key applied before edge N.
    keys = 13'h0004;
    ticks(5);
    check("lat_stable_early", 32'(kstable), 32'h0);
    tick();
    check("lat_stable_n5", 32'(kstable), 32'h4);
    check("lat_note_n5", 32'(note), 32'd0);
    tick();
    check("lat_note_n6", 32'(note), 32'd3);
    check("lat_valid_n6", 32'(nvalid), 32'd1);
    tick();
    check("lat_valid_n7", 32'(nvalid), 32'd0);
    check("lat_note_n7", 32'(note), 32'd3);

    for (int v = 0; v < 4; v++) begin
      strobes = 0;
      keys = vecs[v].keys;
      ticks(vecs[v].hold);
      check($sformatf("vec%0d_note", v), 32'(note), 32'(vecs[v].note));
      check($sformatf("vec%0d_stable", v), 32'(kstable), 32'(vecs[v].stable));
      check($sformatf("vec%0d_strobes", v), 32'(strobes), 32'(vecs[v].strobes));
    end

    // Release: SUSTAIN entered at N+6, note held through N+13, silent at N+14.
    strobes = 0;
    keys = 13'h0;
    ticks(14);
    check("sus_note_hold", 32'(note), 32'd13);
    tick();
    check("sus_note_zero", 32'(note), 32'd0);
    check("sus_strobes", 32'(strobes), 32'd0);

    keys = 13'h0004;
    ticks(12);
    check("play3_note", 32'(note), 32'd3);

    // Same key re-pressed during SUSTAIN: no strobe, stays playing.
    strobes = 0;
    keys = 13'h0;
    ticks(7);
    check("repress_in_sus", 32'(note), 32'd3);
    keys = 13'h0004;
    ticks(17);
    check("repress_same_note", 32'(note), 32'd3);
    check("repress_same_strobes", 32'(strobes), 32'd0);

    // Different key during SUSTAIN: new code, one strobe.
    strobes = 0;
    keys = 13'h0;
    ticks(7);
    keys = 13'h0010;
    ticks(10);
    check("repress_diff_note", 32'(note), 32'd5);
    check("repress_diff_strobes", 32'(strobes), 32'd1);

    // 3-cycle glitch on bit 0 must be ignored.
    begin
      int dev;
      dev = 0;
      strobes = 0;
      keys = 13'h0011;
      tick(); if (kstable != 13'h0010) dev++;
      tick(); if (kstable != 13'h0010) dev++;
      tick(); if (kstable != 13'h0010) dev++;
      keys = 13'h0010;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (kstable != 13'h0010 || note != 8'd5) dev++;
      end
      check("glitch3_deviation", 32'(dev), 32'd0);
      check("glitch3_strobes", 32'(strobes), 32'd0);
    end

    // 4-cycle pulse is exactly long enough to be accepted.
    begin
      int seen;
      seen = 0;
      strobes = 0;
      keys = 13'h0011;
      ticks(4);
      keys = 13'h0010;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (kstable[0]) seen++;
      end
      check("pulse4_seen", 32'(seen > 0), 32'd1);
      check("pulse4_strobes", 32'(strobes), 32'd2);
      check("pulse4_note", 32'(note), 32'd5);
    end

    // Reset in SUSTAIN with note 5, key held through reset.
    keys = 13'h0;
    ticks(8);
    check("rst_pre_note", 32'(note), 32'd5);
    rst  = 1'b1;
    keys = 13'h0010;
    strobes = 0;
    tick();
    check("rst_note", 32'(note), 32'd0);
    check("rst_stable", 32'(kstable), 32'd0);
    check("rst_valid", 32'(nvalid), 32'd0);
    rst = 1'b0;
    begin
      int tail;
      tail = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (note != 8'd0) tail++;
      end
      check("rst_no_tail", 32'(tail), 32'd0);
      check("rst_no_strobe", 32'(strobes), 32'd0);
    end
    tick();
    check("rst_return_note", 32'(note), 32'd5);
    check("rst_return_valid", 32'(nvalid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
